// File: rtl/debug_capture.sv
// debug_capture: timestamps edges on four debug pins and queues them in a
// first-word fall-through event FIFO, with a small IDLE/RUN/DONE capture FSM.
module debug_capture #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [3:0]                    GPIO_IN,
  input  logic [55:0]                   SYS_TIME,
  input  logic [3:0]                    RISE_EN,
  input  logic [3:0]                    FALL_EN,
  input  logic                          ONESHOT,
  input  logic                          START,
  input  logic                          STOP,
  input  logic                          CLEAR,
  input  logic                          RD_EN,
  output logic [63:0]                   RD_DATA,
  output logic                          EMPTY,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          OVERFLOW,
  output logic [7:0]                    DROP_CNT,
  output logic [1:0]                    STATE
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         s1;
  logic [3:0]         s2;
  logic [3:0]         s3;
  logic [3:0]         evt_mask;
  logic               vld_p0;
  logic [63:0]        entry_p0;
  logic [63:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               wr_req;
  logic               wr_acc;
  logic               pop;
  logic               drop;

  // Saturating increment for the dropped-event counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= GPIO_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Qualified edges of this cycle, several channels merge into one mask
  always_comb begin
    evt_mask = (s2 & ~s3 & RISE_EN) | (~s2 & s3 & FALL_EN);
  end

  // Capture stage p0: only edges seen while already in RUN become events
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= (state_q == RUN) && (evt_mask != 4'd0);
    end
  end

  // Capture stage p0 payload: mask, pin levels and timestamp of the edge cycle
  always_ff @(posedge CLK) begin
    entry_p0 <= {evt_mask, s2, SYS_TIME};
  end

  // FIFO write/pop/drop decisions; CLEAR overrides everything
  always_comb begin
    wr_req  = vld_p0 && (state_q == RUN);
    pop     = RD_EN && !EMPTY && !CLEAR;
    wr_acc  = wr_req && (!FULL || pop) && !CLEAR;
    drop    = wr_req && FULL && !pop && !CLEAR;
    count_d = count_q;
    if (CLEAR) begin
      count_d = '0;
    end else if (wr_acc && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !wr_acc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Capture FSM next state; STOP beats START, DONE entered once the FIFO fills
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (START && !STOP) state_d = RUN;
      RUN: begin
        if (STOP) state_d = IDLE;
        else if (ONESHOT && (count_d == DEPTH_C)) state_d = DONE;
      end
      DONE: begin
        if (STOP) state_d = IDLE;
        else if (START) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture FSM state register
  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Event storage array, written at the tail
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= entry_p0;
  end

  // Pointers, registered occupancy flags and overflow bookkeeping
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      OVERFLOW <= 1'b0;
      DROP_CNT <= 8'd0;
    end else begin
      if (CLEAR) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        OVERFLOW <= 1'b0;
        DROP_CNT <= 8'd0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
        if (drop) begin
          OVERFLOW <= 1'b1;
          DROP_CNT <= sat_inc(DROP_CNT);
        end
      end
      count_q <= count_d;
      EMPTY   <= (count_d == '0);
      FULL    <= (count_d == DEPTH_C);
    end
  end

  assign RD_DATA = mem[rd_ptr];
  assign COUNT   = count_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_debug_capture.sv
// tb_debug_capture: randomized and directed stimulus against a queue-based
// reference model; a monitor pops expected entries whenever the DUT pops.
module tb_debug_capture;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  GPIO_IN;
  logic [55:0] SYS_TIME;
  logic [3:0]  RISE_EN;
  logic [3:0]  FALL_EN;
  logic        ONESHOT;
  logic        START;
  logic        STOP;
  logic        CLEAR;
  logic        RD_EN;
  logic [63:0] RD_DATA;
  logic        EMPTY;
  logic        FULL;
  logic [4:0]  COUNT;
  logic        OVERFLOW;
  logic [7:0]  DROP_CNT;
  logic [1:0]  STATE;

  int errors = 0;
  int checks = 0;

  // Reference model: expected FIFO contents and status
  logic [63:0] exp_q[$];
  int          mcnt;
  int          mdrops;
  int          mst;
  logic        movf;
  logic [3:0]  h1, h2, h3;
  logic        pend_vld;
  logic [63:0] pend;
  logic        fixed_time;

  debug_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .GPIO_IN  (GPIO_IN),
    .SYS_TIME (SYS_TIME),
    .RISE_EN  (RISE_EN),
    .FALL_EN  (FALL_EN),
    .ONESHOT  (ONESHOT),
    .START    (START),
    .STOP     (STOP),
    .CLEAR    (CLEAR),
    .RD_EN    (RD_EN),
    .RD_DATA  (RD_DATA),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW),
    .DROP_CNT (DROP_CNT),
    .STATE    (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT pop must deliver the oldest expected entry
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && RD_EN && EMPTY === 1'b0 && !CLEAR) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_underflow: DUT popped %0h with none expected", RD_DATA);
      end else begin
        check("rd_data", RD_DATA, exp_q.pop_front());
      end
    end
  end

  // Advance the model across one clock edge using the inputs applied to it.
  // A pin change sampled at edge e is seen as an edge during the cycle before
  // edge e+2 (timestamped then) and lands in the FIFO at edge e+3.
  task automatic model_step();
    logic [3:0] mask;
    logic       wr;
    logic       pp;
    int         nst;
    if (!RESET_N) begin
      mst = 0; mcnt = 0; movf = 1'b0; mdrops = 0; pend_vld = 1'b0;
      h1 = '0; h2 = '0; h3 = '0;
      exp_q.delete();
      return;
    end
    mask = (h2 & ~h3 & RISE_EN) | (~h2 & h3 & FALL_EN);
    wr   = pend_vld && (mst == 1);
    pp   = RD_EN && (mcnt > 0) && !CLEAR;
    if (CLEAR) begin
      exp_q.delete();
      mcnt = 0; movf = 1'b0; mdrops = 0;
    end else begin
      if (pp) mcnt--;
      if (wr) begin
        if (mcnt < DEPTH) begin
          exp_q.push_back(pend);
          mcnt++;
        end else begin
          movf = 1'b1;
          if (mdrops < 255) mdrops++;
        end
      end
    end
    nst = mst;
    case (mst)
      0: if (START && !STOP) nst = 1;
      1: if (STOP) nst = 0; else if (ONESHOT && mcnt == DEPTH) nst = 2;
      2: if (STOP) nst = 0; else if (START) nst = 1;
      default: nst = 0;
    endcase
    pend_vld = (mst == 1) && (mask != 4'd0);
    pend     = {mask, h2, SYS_TIME};
    mst = nst;
    h3 = h2; h2 = h1; h1 = GPIO_IN;
  endtask

  task automatic check_flags();
    check("state",    STATE,    mst);
    check("count",    COUNT,    mcnt);
    check("empty",    EMPTY,    mcnt == 0);
    check("full",     FULL,     mcnt == DEPTH);
    check("overflow", OVERFLOW, movf);
    check("drop_cnt", DROP_CNT, mdrops);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    model_step();
    check_flags();
    START = 1'b0; STOP = 1'b0; CLEAR = 1'b0;
    SYS_TIME = fixed_time ? 56'h100 : 56'({$urandom(), $urandom()});
  endtask

  task automatic toggle0(input int n);
    for (int i = 0; i < n; i++) begin
      GPIO_IN[0] = ~GPIO_IN[0];
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; GPIO_IN = 4'hF; SYS_TIME = '0; RISE_EN = 4'hF; FALL_EN = 4'hF;
    ONESHOT = 1'b0; START = 1'b0; STOP = 1'b0; CLEAR = 1'b0; RD_EN = 1'b0;
    fixed_time = 1'b0;
    mst = 0; mcnt = 0; movf = 1'b0; mdrops = 0; pend_vld = 1'b0;
    h1 = '0; h2 = '0; h3 = '0; pend = '0;

    // Reset with pins high; the 0->1 seen after release is ignored in IDLE
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (5) tick();
    check("post_reset_empty", EMPTY, 1'b1);

    // Single rising edge on channel 0 with a fixed timestamp
    RISE_EN = 4'b0001; FALL_EN = 4'b0000; GPIO_IN = 4'h0;
    fixed_time = 1'b1; SYS_TIME = 56'h100;
    repeat (5) tick();
    START = 1'b1; tick();
    GPIO_IN = 4'b0001; tick();
    tick(); check("first_edge_empty_e1", EMPTY, 1'b1);
    tick(); check("first_edge_empty_e2", EMPTY, 1'b1);
    tick(); check("first_edge_empty_e3", EMPTY, 1'b0);
    check("first_edge_entry", RD_DATA, 64'h1100_0000_0000_0100);
    RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    fixed_time = 1'b0;

    // Four simultaneous toggles merge into one entry
    RISE_EN = 4'hF; FALL_EN = 4'hF;
    STOP = 1'b1; tick();
    GPIO_IN = 4'h0; repeat (4) tick();
    CLEAR = 1'b1; tick();
    START = 1'b1; tick();
    GPIO_IN = 4'hF; repeat (5) tick();
    check("merge_count", COUNT, 5'd1);
    check("merge_mask", RD_DATA[63:60], 4'hF);
    check("merge_levels", RD_DATA[59:56], 4'hF);
    RD_EN = 1'b1; tick(); RD_EN = 1'b0;

    // Continuous mode: 20 edges into 16 slots
    ONESHOT = 1'b0; CLEAR = 1'b1; tick();
    toggle0(20);
    repeat (4) tick();
    check("cont_count", COUNT, 5'd16);
    check("cont_full", FULL, 1'b1);
    check("cont_overflow", OVERFLOW, 1'b1);
    check("cont_drops", DROP_CNT, 8'd4);

    // Full FIFO: write and pop on the same edge
    GPIO_IN[0] = ~GPIO_IN[0]; tick();
    tick(); tick();
    RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    check("full_wr_pop_count", COUNT, 5'd16);
    check("full_wr_pop_ovf", OVERFLOW, 1'b1);
    check("full_wr_pop_drops", DROP_CNT, 8'd4);
    RD_EN = 1'b1; repeat (16) tick(); RD_EN = 1'b0;
    check("cont_drained", EMPTY, 1'b1);

    // One-shot mode stops at full without drops, START resumes
    ONESHOT = 1'b1; CLEAR = 1'b1; tick();
    toggle0(20);
    repeat (4) tick();
    check("oneshot_state", STATE, 2'd2);
    check("oneshot_drops", DROP_CNT, 8'd0);
    check("oneshot_count", COUNT, 5'd16);
    START = 1'b1; tick();
    check("oneshot_restart", STATE, 2'd1);
    ONESHOT = 1'b0;
    toggle0(3);
    repeat (4) tick();
    check("restart_ovf", OVERFLOW, 1'b1);

    // CLEAR coinciding with a write and a pop
    GPIO_IN[0] = ~GPIO_IN[0]; tick();
    tick(); tick();
    CLEAR = 1'b1; RD_EN = 1'b1; tick(); RD_EN = 1'b0;
    check("clear_count", COUNT, 5'd0);
    check("clear_empty", EMPTY, 1'b1);
    check("clear_ovf", OVERFLOW, 1'b0);
    check("clear_state", STATE, 2'd1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) GPIO_IN = 4'($urandom());
      if ($urandom_range(0, 99) == 0) begin
        RISE_EN = 4'($urandom());
        FALL_EN = 4'($urandom());
        ONESHOT = 1'($urandom_range(0, 1));
      end
      RD_EN = ($urandom_range(0, 2) == 0);
      START = ($urandom_range(0, 19) == 0);
      STOP  = ($urandom_range(0, 59) == 0);
      CLEAR = ($urandom_range(0, 149) == 0);
      tick();
    end

    // Reset in the middle of a run
    RD_EN = 1'b0; ONESHOT = 1'b0; RISE_EN = 4'hF; FALL_EN = 4'hF;
    START = 1'b1; tick();
    toggle0(4);
    check("midrun_state", STATE, 2'd1);
    RESET_N = 1'b0; tick();
    check("midrun_reset_state", STATE, 2'd0);
    check("midrun_reset_count", COUNT, 5'd0);
    GPIO_IN = 4'hF; tick();
    RESET_N = 1'b1; repeat (6) tick();
    check("reset_release_empty", EMPTY, 1'b1);

    // Final capture and drain
    START = 1'b1; tick();
    toggle0(6);
    repeat (4) tick();
    RD_EN = 1'b1; repeat (DEPTH + 8) tick(); RD_EN = 1'b0;
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
